// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core data-memory request bus plus the single-port RAM
// port, shared by the arbiter (slave) and the core/RAM side (master).
interface mem_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int CORE_NUM   = 4,
    parameter int ADDR_WIDTH = 16
);
    logic [CORE_NUM-1:0]       request;
    logic [CORE_NUM-1:0]       wren_in;
    logic [CORE_NUM*WIDTH-1:0] address_in;
    logic [CORE_NUM*WIDTH-1:0] writedata_in;
    logic [CORE_NUM-1:0]       response;
    logic [WIDTH-1:0]          readdata;
    logic [ADDR_WIDTH-1:0]     mem_address;
    logic [WIDTH-1:0]          mem_writedata;
    logic                      mem_wren;
    logic [WIDTH-1:0]          mem_readdata;

    modport master (
        output request,
        output wren_in,
        output address_in,
        output writedata_in,
        output mem_readdata,
        input  response,
        input  readdata,
        input  mem_address,
        input  mem_writedata,
        input  mem_wren
    );

    modport slave (
        input  request,
        input  wren_in,
        input  address_in,
        input  writedata_in,
        input  mem_readdata,
        output response,
        output readdata,
        output mem_address,
        output mem_writedata,
        output mem_wren
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CORE_NUM core data-memory ports onto one RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mem_arbiter #(
    parameter int WIDTH       = 32,
    parameter int CORE_NUM    = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int GW = $clog2(CORE_NUM);
    localparam int CW = $clog2(MEM_LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                state;
    logic [GW-1:0]         grant;
    logic [CW-1:0]         cnt;
    logic                  is_write;

    logic                  found;
    logic [GW-1:0]         win;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic                  sel_wren;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr;

    // Outer loop is distance from ptr, so the first hit is the nearest
    // requester scanning upward modulo CORE_NUM.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            for (int j = 0; j < CORE_NUM; j++) begin
                if (!found && bus.request[j] &&
                    ((int'(ptr) + k == j) ||
                     (int'(ptr) + k == j + CORE_NUM))) begin
                    found = 1'b1;
                    win   = GW'(j);
                end
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < CORE_NUM; j++) begin
            if (!found && bus.request[j]) begin
                found = 1'b1;
                win   = GW'(j);
            end
        end
    end
`endif

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wren  = 1'b0;
        for (int j = 0; j < CORE_NUM; j++) begin
            if (win == GW'(j)) begin
                sel_addr  = bus.address_in[j*WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.writedata_in[j*WIDTH +: WIDTH];
                sel_wren  = bus.wren_in[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            grant             <= '0;
            cnt               <= '0;
            is_write          <= 1'b0;
            bus.response      <= '0;
            bus.readdata      <= '0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
            bus.mem_wren      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr               <= '0;
`endif
        end else begin
            bus.response <= '0;
            bus.mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state             <= ACCESS;
                        grant             <= win;
                        is_write          <= sel_wren;
                        bus.mem_address   <= sel_addr;
                        bus.mem_writedata <= sel_wdata;
                        bus.mem_wren      <= sel_wren;
                        cnt               <= CW'(MEM_LATENCY - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (win == GW'(CORE_NUM - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= win + GW'(1);
                        end
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!is_write) begin
                            bus.readdata <= bus.mem_readdata;
                        end
                        bus.response <= CORE_NUM'(1) << grant;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a
// transaction-level model (arbitration policy, latency, RAM contents).
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(W), .CORE_NUM(N), .ADDR_WIDTH(AW)) bus ();
    mem_arbiter_if #(.WIDTH(W), .CORE_NUM(N), .ADDR_WIDTH(AW)) bus1 ();

    mem_arbiter #(
        .WIDTH(W), .CORE_NUM(N), .ADDR_WIDTH(AW), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    mem_arbiter #(
        .WIDTH(W), .CORE_NUM(N), .ADDR_WIDTH(AW), .MEM_LATENCY(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    // RAM behind dut; a fixed address function behind dut1
    logic [W-1:0] ram [256];
    assign bus.mem_readdata = ram[bus.mem_address[7:0]];
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_address[7:0]] <= bus.mem_writedata;
    end
    assign bus1.mem_readdata = W'(bus1.mem_address) * 32'd3 + 32'd7;

    int checks = 0;
    int fails  = 0;

    // reference model state
    logic [W-1:0] ref_mem [int];
    logic [W-1:0] exp_rd = '0;
    int           rr_ptr = 0;
    logic [N-1:0] pend = '0;
    logic [W-1:0] c_addr [N];
    logic [W-1:0] c_data [N];
    logic         c_wr   [N];

    int           wcnt;
    logic [AW-1:0] w_addr;
    logic [W-1:0] w_data;

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.mem_wren) begin
            wcnt++;
            w_addr = bus.mem_address;
            w_data = bus.mem_writedata;
        end
    endtask

    task automatic drive();
        bus.request = pend;
        for (int i = 0; i < N; i++) begin
            bus.wren_in[i] = c_wr[i];
            bus.address_in[i*W +: W] = c_addr[i];
            bus.writedata_in[i*W +: W] = c_data[i];
        end
    endtask

    task automatic rand_ops(input int i);
        c_addr[i] = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 255));
        c_data[i] = $urandom();
        c_wr[i]   = 1'($urandom_range(0, 1));
    endtask

    function automatic int pick(input logic [N-1:0] p);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (p[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
        end
`else
        for (int j = 0; j < N; j++) begin
            if (p[j]) return j;
        end
`endif
        return 0;
    endfunction

    task automatic wait_resp(input int max_steps, output int steps,
                             output logic [N-1:0] r);
        steps = 0;
        r = '0;
        while (steps < max_steps && r == '0) begin
            step();
            steps++;
            r = bus.response;
        end
    endtask

    // One model transaction: winner, latency, RAM side effects, readdata.
    task automatic run_txn(input int exp_steps, input string tag,
                           output int w, output logic [N-1:0] r);
        int steps;
        int key;
        logic [N-1:0] exp_r;
        logic [W-1:0] want_rd;
        w = pick(pend);
        key = int'(c_addr[w] % 32'h0001_0000);
        if (!ref_mem.exists(key)) ref_mem[key] = '0;
        want_rd = c_wr[w] ? exp_rd : ref_mem[key];
        exp_r = '0;
        exp_r[w] = 1'b1;
        wcnt = 0;
        wait_resp(exp_steps + 3, steps, r);
        checks++;
        if (steps != exp_steps)
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, steps, exp_steps);
        if (steps != exp_steps) fails++;
        checks++;
        if (r !== exp_r) begin
            fails++;
            $display("FAIL %s response: got %b, expected %b", tag, r, exp_r);
        end
        checks++;
        if (bus.readdata !== want_rd) begin
            fails++;
            $display("FAIL %s readdata: got %h, expected %h", tag, bus.readdata, want_rd);
        end
        checks++;
        if (bus.mem_address !== AW'(key)) begin
            fails++;
            $display("FAIL %s mem_address: got %h, expected %h", tag, bus.mem_address, key);
        end
        checks++;
        if (wcnt != (c_wr[w] ? 1 : 0)) begin
            fails++;
            $display("FAIL %s wren pulses: got %0d, expected %0d", tag, wcnt, c_wr[w] ? 1 : 0);
        end
        if (c_wr[w] && wcnt == 1) begin
            checks++;
            if (w_addr !== AW'(key) || w_data !== c_data[w]) begin
                fails++;
                $display("FAIL %s write: got %h/%h, expected %h/%h",
                         tag, w_addr, w_data, key, c_data[w]);
            end
        end
        if (c_wr[w]) ref_mem[key] = c_data[w];
        else exp_rd = want_rd;
        rr_ptr = (w + 1) % N;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.response !== '0 || bus.mem_wren !== 1'b0) begin
            fails++;
            $display("FAIL reset response/wren: got %b/%b, expected 0/0", bus.response, bus.mem_wren);
        end
        checks++;
        if (bus.readdata !== '0) begin
            fails++;
            $display("FAIL reset readdata: got %h, expected 0", bus.readdata);
        end
        checks++;
        if (bus.mem_address !== '0 || bus.mem_writedata !== '0) begin
            fails++;
            $display("FAIL reset mem bus: got %h/%h, expected 0/0", bus.mem_address, bus.mem_writedata);
        end
        reset_n = 1'b1;
        exp_rd = '0;
        rr_ptr = 0;
        step();
    endtask

    task automatic test_single_read();
        int w;
        logic [N-1:0] r;
        ram[8'h10] = 32'hDEAD_BEEF;
        ref_mem[16'h10] = 32'hDEAD_BEEF;
        c_addr[1] = 32'h0000_0010;
        c_wr[1] = 1'b0;
        c_data[1] = '0;
        pend = 4'b0010;
        drive();
        run_txn(L + 1, "single_read", w, r);
        checks++;
        if (bus.readdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_read data: got %h, expected deadbeef", bus.readdata);
        end
        // request stays high through RESP, then drops
        step();
        pend = '0;
        drive();
        r = '0;
        wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            r |= bus.response;
        end
        checks++;
        if (r !== '0 || wcnt != 0) begin
            fails++;
            $display("FAIL held_through_resp: got response %b wren %0d, expected 0", r, wcnt);
        end
    endtask

    task automatic test_single_write();
        int w;
        logic [N-1:0] r;
        c_addr[0] = 32'h0000_0020;
        c_data[0] = 32'h1234_5678;
        c_wr[0] = 1'b1;
        pend = 4'b0001;
        drive();
        run_txn(L + 1, "single_write", w, r);
        pend = '0;
        drive();
        step();
    endtask

    task automatic test_truncation();
        int w;
        logic [N-1:0] r;
        c_addr[3] = 32'hFFFF_0042;
        c_wr[3] = 1'b0;
        pend = 4'b1000;
        drive();
        run_txn(L + 1, "truncation", w, r);
        checks++;
        if (bus.mem_address !== 16'h0042) begin
            fails++;
            $display("FAIL truncation addr: got %h, expected 0042", bus.mem_address);
        end
        pend = '0;
        drive();
        step();
    endtask

    task automatic test_contention();
        int w;
        logic [N-1:0] r;
        int exp_order [6];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 2, 3, 0, 2, 3};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        foreach (c_addr[i]) rand_ops(i);
        pend = 4'b1101;
        drive();
        for (int i = 0; i < 6; i++) begin
            run_txn(i == 0 ? L + 1 : L + 2, "contention", w, r);
            checks++;
            if (r !== 4'(1 << exp_order[i])) begin
                fails++;
                $display("FAIL contention order %0d: got %b, expected core %0d", i, r, exp_order[i]);
            end
        end
        pend = '0;
        drive();
        step();
    endtask

    task automatic test_reset_mid_op();
        int w;
        logic [N-1:0] r;
        c_addr[2] = 32'h0000_0030;
        c_wr[2] = 1'b0;
        pend = 4'b0100;
        drive();
        step();
        step();
        reset_n = 1'b0;
        step();
        checks++;
        if (bus.response !== '0 || bus.mem_wren !== 1'b0 || bus.readdata !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs: got %b/%b/%h, expected 0", bus.response, bus.mem_wren, bus.readdata);
        end
        checks++;
        if (bus.mem_address !== '0 || bus.mem_writedata !== '0) begin
            fails++;
            $display("FAIL reset_mid mem bus: got %h/%h, expected 0/0", bus.mem_address, bus.mem_writedata);
        end
        reset_n = 1'b1;
        exp_rd = '0;
        rr_ptr = 0;
        run_txn(L + 1, "reset_mid_regrant", w, r);
        pend = '0;
        drive();
        step();
    endtask

    task automatic test_random();
        int w;
        logic [N-1:0] r;
        pend = N'($urandom_range(1, 15));
        foreach (c_addr[i]) rand_ops(i);
        drive();
        run_txn(L + 1, "random", w, r);
        for (int n = 0; n < 40; n++) begin
            pend[w] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    rand_ops(i);
                    pend[i] = 1'b1;
                end
            end
            if (pend == '0) begin
                w = $urandom_range(0, N - 1);
                rand_ops(w);
                pend[w] = 1'b1;
            end
            drive();
            run_txn(L + 2, "random", w, r);
        end
        pend = '0;
        drive();
        step();
    endtask

    task automatic test_latency1();
        int steps;
        logic wseen;
        logic [N-1:0] r;
        bus1.address_in[W-1:0] = 32'hABCD_0005;
        bus1.wren_in = '0;
        bus1.request = 4'b0001;
        steps = 0;
        wseen = 1'b0;
        while (steps < 6 && bus1.response == '0) begin
            @(posedge clk);
            #1;
            steps++;
            wseen |= bus1.mem_wren;
        end
        checks++;
        if (steps != 2 || bus1.response !== 4'b0001) begin
            fails++;
            $display("FAIL lat1 response: got %b after %0d cycles, expected 0001 after 2", bus1.response, steps);
        end
        checks++;
        if (bus1.readdata !== 32'd22 || bus1.mem_address !== 16'h0005) begin
            fails++;
            $display("FAIL lat1 data: got %h @%h, expected 00000016 @0005", bus1.readdata, bus1.mem_address);
        end
        checks++;
        if (wseen !== 1'b0 || bus1.mem_writedata !== '0) begin
            fails++;
            $display("FAIL lat1 write side: got wren %b data %h, expected 0/0", wseen, bus1.mem_writedata);
        end
        @(posedge clk);
        #1;
        bus1.request = '0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            r |= bus1.response;
        end
        checks++;
        if (r !== '0) begin
            fails++;
            $display("FAIL lat1 no regrant: got %b, expected 0000", r);
        end
    endtask

    initial begin
        bus.request = '0;
        bus.wren_in = '0;
        bus.address_in = '0;
        bus.writedata_in = '0;
        bus1.request = '0;
        bus1.wren_in = '0;
        bus1.address_in = '0;
        bus1.writedata_in = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom();
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_single_read();
        test_single_write();
        test_truncation();
        test_contention();
        test_reset_mid_op();
        test_random();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
